// File: rtl/scan_chain_deserializer_if.sv
// Parallel-side bundle of the scan-chain receiver: scan/strobe inputs plus the
// committed word and status that return to the CPU top level.
interface scan_chain_deserializer_if #(
    parameter int CHAIN_LEN = 24,
    parameter int CNT_WIDTH = 6
);
    logic                 EN;
    logic                 SCLK1;
    logic                 SCLK2;
    logic                 LAT;
    logic                 SPI_SI;
    logic                 ACK;
    logic [CHAIN_LEN-1:0] PO;
    logic                 DONE;
    logic                 BUSY;
    logic [CNT_WIDTH-1:0] BIT_CNT;
    logic                 LEN_ERR;
    logic                 PHASE_ERR;

    modport master (
        output EN, SCLK1, SCLK2, LAT, SPI_SI, ACK,
        input  PO, DONE, BUSY, BIT_CNT, LEN_ERR, PHASE_ERR
    );

    modport slave (
        input  EN, SCLK1, SCLK2, LAT, SPI_SI, ACK,
        output PO, DONE, BUSY, BIT_CNT, LEN_ERR, PHASE_ERR
    );
endinterface

// File: rtl/scan_chain_deserializer.sv
// Oversampling receiver for the two-phase pseudo-SPI scan chain: captures on
// SCLK1, shifts on SCLK2 and commits the assembled word on a LAT rise.
module scan_chain_deserializer #(
    parameter int CHAIN_LEN = 24,
    parameter int CNT_WIDTH = 6
) (
    input logic                       CLK,
    input logic                       RST,
    scan_chain_deserializer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HALF, FULL} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CHAIN_LEN);

    state_t state, state_next;

    // Bit order: {SPI_SI, LAT, SCLK2, SCLK1}; data needs no edge history.
    logic [3:0] raw, meta, sync;
    logic [2:0] hist, rise;
    logic       s1_rise, s2_rise, lat_rise, si_sync;

    logic [CHAIN_LEN-1:0] sr, sr_next, po, po_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic cap, cap_next;
    logic done, done_next;
    logic len_err, len_err_next;
    logic phase_err, phase_err_next;
    logic commit, violation;

    assign raw      = {bus.SPI_SI, bus.LAT, bus.SCLK2, bus.SCLK1};
    assign rise     = sync[2:0] & ~hist;
    assign s1_rise  = rise[0];
    assign s2_rise  = rise[1];
    assign lat_rise = rise[2];
    assign si_sync  = sync[3];

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= '0;
            sync <= '0;
            hist <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            hist <= sync[2:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Priority: disable > commit > double clock rise > single clock rise.
    always_comb begin
        state_next   = state;
        cap_next     = cap;
        sr_next      = sr;
        cnt_next     = cnt;
        po_next      = po;
        len_err_next = len_err;
        commit       = 1'b0;
        violation    = 1'b0;

        if (!bus.EN) begin
            state_next = IDLE;
            cap_next   = 1'b0;
            sr_next    = '0;
            cnt_next   = '0;
        end else if (lat_rise) begin
            commit       = 1'b1;
            po_next      = sr;
            len_err_next = (cnt != CNT_FULL) || (state == HALF);
            cap_next     = 1'b0;
            sr_next      = '0;
            cnt_next     = '0;
            state_next   = IDLE;
        end else if (s1_rise && s2_rise) begin
            violation = 1'b1;
        end else if (s1_rise) begin
            cap_next   = si_sync;
            state_next = HALF;
            if (state == HALF) violation = 1'b1;
        end else if (s2_rise) begin
            if (state == HALF) begin
                sr_next    = {sr[CHAIN_LEN-2:0], cap};
                state_next = FULL;
                if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;
            end else begin
                violation = 1'b1;
            end
        end

        // A set in the same cycle as ACK wins over the clear.
        done_next      = commit | (done & ~bus.ACK);
        phase_err_next = violation | (phase_err & ~bus.ACK);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cap       <= 1'b0;
            sr        <= '0;
            cnt       <= '0;
            po        <= '0;
            done      <= 1'b0;
            len_err   <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            cap       <= cap_next;
            sr        <= sr_next;
            cnt       <= cnt_next;
            po        <= po_next;
            done      <= done_next;
            len_err   <= len_err_next;
            phase_err <= phase_err_next;
        end
    end

    assign bus.PO        = po;
    assign bus.DONE      = done;
    assign bus.BUSY      = (state != IDLE);
    assign bus.BIT_CNT   = cnt;
    assign bus.LEN_ERR   = len_err;
    assign bus.PHASE_ERR = phase_err;
endmodule

// File: tb/tb_scan_chain_deserializer.sv
// Directed bench for scan_chain_deserializer: a frame-level model tracks the
// expected outputs and is compared every cycle once synchronizer latency has passed.
module tb_scan_chain_deserializer;
    localparam int CL = 24;
    localparam int CW = 6;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    scan_chain_deserializer_if #(.CHAIN_LEN(CL), .CNT_WIDTH(CW)) bus ();
    scan_chain_deserializer #(.CHAIN_LEN(CL), .CNT_WIDTH(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hold_until = 0;
    bit cmp_on = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Frame-level expectation: pending captured bit, shifted bits, committed word.
    logic [CL-1:0] m_sr, m_po;
    logic m_pbit;
    bit   m_pending, m_busy, m_done, m_len_err, m_phase_err;
    int   m_cnt;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_abort();
        m_sr = '0; m_cnt = 0; m_pending = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_reset();
        model_abort();
        m_po = '0; m_pbit = 1'b0; m_done = 1'b0; m_len_err = 1'b0; m_phase_err = 1'b0;
    endtask

    task automatic model_sclk1(input logic b);
        if (m_pending) m_phase_err = 1'b1;
        m_pending = 1'b1;
        m_pbit = b;
        m_busy = 1'b1;
    endtask

    task automatic model_sclk2();
        if (m_pending) begin
            m_sr = {m_sr[CL-2:0], m_pbit};
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            m_pending = 1'b0;
        end else begin
            m_phase_err = 1'b1;
        end
    endtask

    task automatic model_lat();
        m_po = m_sr;
        m_done = 1'b1;
        m_len_err = (m_cnt != CL) || m_pending;
        model_abort();
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge CLK);
            if (cmp_on && cyc >= hold_until) begin
                check_output("po", 32'(bus.PO), 32'(m_po));
                check_output("done", 32'(bus.DONE), 32'(m_done));
                check_output("busy", 32'(bus.BUSY), 32'(m_busy));
                check_output("bit_cnt", 32'(bus.BIT_CNT), 32'(m_cnt));
                check_output("len_err", 32'(bus.LEN_ERR), 32'(m_len_err));
                check_output("phase_err", 32'(bus.PHASE_ERR), 32'(m_phase_err));
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sclk1_pulse(input logic b);
        bus.SPI_SI = b;
        tick(1);
        bus.SCLK1 = 1'b1;
        model_sclk1(b);
        hold_until = cyc + 3;
        tick(4);
        bus.SCLK1 = 1'b0;
        tick(2);
    endtask

    task automatic sclk2_pulse();
        bus.SCLK2 = 1'b1;
        model_sclk2();
        hold_until = cyc + 3;
        tick(4);
        bus.SCLK2 = 1'b0;
        tick(2);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sclk1_pulse(val[i]);
            sclk2_pulse();
        end
    endtask

    // chk_lat pins the commit to the second edge after LAT is first sampled high.
    task automatic lat_pulse(input bit with_ack, input bit chk_lat);
        bus.LAT = 1'b1;
        model_lat();
        hold_until = cyc + 3;
        if (chk_lat) begin
            tick(1);
            check_output("lat_edge_k", 32'(bus.DONE), 32'd0);
            tick(1);
            check_output("lat_edge_k1", 32'(bus.DONE), 32'd0);
            tick(1);
            check_output("lat_edge_k2", 32'(bus.DONE), 32'd1);
        end else if (with_ack) begin
            m_phase_err = 1'b0;
            tick(2);
            bus.ACK = 1'b1;
            tick(1);
            bus.ACK = 1'b0;
        end else begin
            tick(3);
        end
        tick(1);
        bus.LAT = 1'b0;
        tick(2);
    endtask

    task automatic ack_pulse();
        bus.ACK = 1'b1;
        m_done = 1'b0;
        m_phase_err = 1'b0;
        hold_until = cyc + 1;
        tick(1);
        bus.ACK = 1'b0;
    endtask

    task automatic rst_pulse();
        RST = 1'b1;
        model_reset();
        hold_until = cyc + 1;
        tick(1);
        RST = 1'b0;
    endtask

    initial begin
        bus.EN = 1'b0; bus.SCLK1 = 1'b0; bus.SCLK2 = 1'b0;
        bus.LAT = 1'b0; bus.SPI_SI = 1'b0; bus.ACK = 1'b0;
        RST = 1'b1;
        model_reset();
        fork
            compare_loop();
        join_none
        tick(2);
        RST = 1'b0;

        check_output("reset_po", 32'(bus.PO), 32'd0);
        check_output("reset_done", 32'(bus.DONE), 32'd0);
        check_output("reset_busy", 32'(bus.BUSY), 32'd0);
        check_output("reset_cnt", 32'(bus.BIT_CNT), 32'd0);
        check_output("reset_len_err", 32'(bus.LEN_ERR), 32'd0);
        check_output("reset_phase_err", 32'(bus.PHASE_ERR), 32'd0);

        bus.EN = 1'b1;
        cmp_on = 1'b1;
        tick(2);

        $display("[TB] full frame 0xA5C33C");
        send_bits(32'hA5C33C, 24);
        check_output("t1_cnt", 32'(bus.BIT_CNT), 32'd24);
        lat_pulse(1'b0, 1'b1);
        check_output("t1_po", 32'(bus.PO), 32'hA5C33C);
        check_output("t1_len_err", 32'(bus.LEN_ERR), 32'd0);
        check_output("t1_phase_err", 32'(bus.PHASE_ERR), 32'd0);
        check_output("t1_cnt_clr", 32'(bus.BIT_CNT), 32'd0);
        ack_pulse();
        check_output("t1_ack_done", 32'(bus.DONE), 32'd0);

        $display("[TB] short and long frames");
        send_bits(32'hFFFFF, 20);
        lat_pulse(1'b0, 1'b0);
        check_output("t2_short_po", 32'(bus.PO), 32'h0FFFFF);
        check_output("t2_short_len_err", 32'(bus.LEN_ERR), 32'd1);
        check_output("t2_short_done", 32'(bus.DONE), 32'd1);
        ack_pulse();
        send_bits(32'h3123456, 26);
        check_output("t2_long_cnt", 32'(bus.BIT_CNT), 32'd26);
        lat_pulse(1'b0, 1'b0);
        check_output("t2_long_po", 32'(bus.PO), 32'h123456);
        check_output("t2_long_len_err", 32'(bus.LEN_ERR), 32'd1);
        ack_pulse();

        $display("[TB] phase violations");
        sclk1_pulse(1'b1);
        sclk1_pulse(1'b0);
        sclk2_pulse();
        check_output("t3_dbl_phase_err", 32'(bus.PHASE_ERR), 32'd1);
        check_output("t3_dbl_cnt", 32'(bus.BIT_CNT), 32'd1);
        lat_pulse(1'b0, 1'b0);
        check_output("t3_dbl_bit", 32'(bus.PO), 32'd0);
        ack_pulse();
        check_output("t3_ack1_phase_err", 32'(bus.PHASE_ERR), 32'd0);
        sclk2_pulse();
        check_output("t3_idle_phase_err", 32'(bus.PHASE_ERR), 32'd1);
        check_output("t3_idle_cnt", 32'(bus.BIT_CNT), 32'd0);
        ack_pulse();
        check_output("t3_ack2_phase_err", 32'(bus.PHASE_ERR), 32'd0);

        $display("[TB] reset and disable mid-frame");
        send_bits(32'h3FF, 10);
        rst_pulse();
        send_bits(32'h00F00F, 24);
        lat_pulse(1'b0, 1'b0);
        check_output("t4_rst_po", 32'(bus.PO), 32'h00F00F);
        check_output("t4_rst_len_err", 32'(bus.LEN_ERR), 32'd0);
        ack_pulse();
        send_bits(32'h2AA, 10);
        bus.EN = 1'b0;
        model_abort();
        hold_until = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_output("t4_en_po_hold", 32'(bus.PO), 32'h00F00F);
        end
        bus.EN = 1'b1;
        tick(1);
        send_bits(32'h00F00F, 24);
        lat_pulse(1'b0, 1'b0);
        check_output("t4_en_po", 32'(bus.PO), 32'h00F00F);
        check_output("t4_en_len_err", 32'(bus.LEN_ERR), 32'd0);

        $display("[TB] commit with ack, commit in HALF");
        send_bits(32'h5A5A5A, 24);
        lat_pulse(1'b1, 1'b0);
        check_output("t5_ack_done", 32'(bus.DONE), 32'd1);
        check_output("t5_ack_po", 32'(bus.PO), 32'h5A5A5A);
        ack_pulse();
        send_bits(32'hC0FFEE, 24);
        sclk1_pulse(1'b1);
        check_output("t5_half_busy", 32'(bus.BUSY), 32'd1);
        lat_pulse(1'b0, 1'b0);
        check_output("t5_half_len_err", 32'(bus.LEN_ERR), 32'd1);
        check_output("t5_half_po", 32'(bus.PO), 32'hC0FFEE);
        check_output("t5_half_cnt", 32'(bus.BIT_CNT), 32'd0);
        sclk2_pulse();
        tick(2);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
